// File: rtl/id_hazard_ctrl.sv
// id_hazard_ctrl: ID-stage sequencing (load-use stall, mul/div hold, branch flush); HAZ_STALL_CNT_EN adds a stall counter
module id_hazard_ctrl #(
   parameter int MD_MAX_CYCLES = 64,
   parameter int CNT_W = 16
) (
   input  logic             clock,
   input  logic             reset,
   input  logic [31:0]      if_id_instr,
   input  logic             id_ex_memread,
   input  logic [4:0]       id_ex_rd,
   input  logic             ex_branch_taken,
   input  logic             md_done,
   output logic             md_start,
   output logic             pc_write,
   output logic             if_id_write,
   output logic             if_id_flush,
   output logic             id_ex_bubble,
   output logic             md_timeout,
   output logic [CNT_W-1:0] stall_count
);
   localparam int MW = $clog2(MD_MAX_CYCLES);
   typedef enum logic [1:0] {RUN, MDWAIT, FLUSH} state_t;
   state_t state, state_nxt;
   logic [MW-1:0] wcnt;
   logic [6:0] opcode;
   logic use_rs1, use_rs2, load_haz, is_md, md_last, rel, flush_c, unused_bits;
   assign opcode = if_id_instr[6:0];
   assign unused_bits = ^if_id_instr[14:7];
   assign use_rs1 = !(opcode inside {7'b0110111, 7'b0010111, 7'b1101111});
   assign use_rs2 = opcode inside {7'b0110011, 7'b0100011, 7'b1100011};
   assign load_haz = id_ex_memread && id_ex_rd != 5'd0 &&
                     ((use_rs1 && if_id_instr[19:15] == id_ex_rd) || (use_rs2 && if_id_instr[24:20] == id_ex_rd));
   assign is_md = opcode == 7'b0110011 && if_id_instr[31:25] == 7'b0000001;
   assign md_last = wcnt == MW'(MD_MAX_CYCLES - 1);
   assign rel = md_done || md_last;
   assign flush_c = ex_branch_taken || state == FLUSH;
   // state register and mul/div wait counter (counter restarts whenever not waiting)
   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         state <= RUN;
         wcnt <= '0;
      end else begin
         state <= state_nxt;
         wcnt <= (state == MDWAIT) ? wcnt + MW'(1) : '0;
      end
   end
   // next state: a branch always wins, a load hazard defers the mul/div launch
   always_comb begin
      state_nxt = ex_branch_taken ? FLUSH :
                  (state == RUN && is_md && !load_haz) ? MDWAIT :
                  (state == MDWAIT && !rel) ? MDWAIT : RUN;
   end
   // outputs from state plus live inputs, forced to idle values while reset is held
   always_comb begin
      md_start = reset && !flush_c && state != MDWAIT && !load_haz && is_md;
      pc_write = !reset || flush_c || (state == MDWAIT ? rel : !(load_haz || is_md));
      if_id_write = pc_write;
      if_id_flush = reset && flush_c;
      id_ex_bubble = reset && (flush_c || !pc_write);
      md_timeout = reset && !flush_c && state == MDWAIT && md_last && !md_done;
   end
`ifdef HAZ_STALL_CNT_EN
   // count cycles with the PC held, saturating at all-ones
   always_ff @(posedge clock or negedge reset) begin
      if (!reset) stall_count <= '0;
      else if (!pc_write && !(&stall_count)) stall_count <= stall_count + CNT_W'(1);
   end
`else
   assign stall_count = '0;
`endif
endmodule

// File: tb/tb_id_hazard_ctrl.sv
// tb_id_hazard_ctrl: directed and random stimulus checked against a behavioural model every cycle
module tb_id_hazard_ctrl;
   localparam int MAXC = 8;
   localparam int CW = 16;
   localparam logic [31:0] ADD    = {7'b0, 5'd7, 5'd5, 3'b0, 5'd6, 7'b0110011};
   localparam logic [31:0] ADD_X0 = {7'b0, 5'd0, 5'd0, 3'b0, 5'd1, 7'b0110011};
   localparam logic [31:0] LUI5   = {12'h0, 5'd5, 3'b0, 5'd5, 7'b0110111};
   localparam logic [31:0] SW5    = {7'b0, 5'd5, 5'd1, 3'b010, 5'd0, 7'b0100011};
   localparam logic [31:0] ADDI5  = {7'b0, 5'd5, 5'd2, 3'b0, 5'd1, 7'b0010011};
   localparam logic [31:0] MUL    = {7'b0000001, 5'd2, 5'd1, 3'b0, 5'd6, 7'b0110011};
   localparam logic [31:0] NOP    = 32'h0000_0013;
   localparam logic [31:0] JAL5   = {12'h0, 5'd5, 3'b0, 5'd1, 7'b1101111};
   localparam logic [31:0] BEQ    = {7'b0, 5'd3, 5'd5, 3'b0, 5'd0, 7'b1100011};
   logic clock = 1'b0, reset = 1'b0;
   logic [31:0] if_id_instr;
   logic id_ex_memread, ex_branch_taken, md_done;
   logic [4:0] id_ex_rd;
   logic md_start, pc_write, if_id_write, if_id_flush, id_ex_bubble, md_timeout;
   logic [CW-1:0] stall_count;
   int passed = 0, total = 0;
   bit m_wait = 0, m_flush = 0;
   int m_n = 0, m_sc = 0;
   logic [31:0] itab [9];

   id_hazard_ctrl #(.MD_MAX_CYCLES(MAXC), .CNT_W(CW)) dut (
      .clock(clock), .reset(reset), .if_id_instr(if_id_instr), .id_ex_memread(id_ex_memread),
      .id_ex_rd(id_ex_rd), .ex_branch_taken(ex_branch_taken), .md_done(md_done),
      .md_start(md_start), .pc_write(pc_write), .if_id_write(if_id_write), .if_id_flush(if_id_flush),
      .id_ex_bubble(id_ex_bubble), .md_timeout(md_timeout), .stall_count(stall_count)
   );

   always #5 clock = ~clock;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      total++;
      if (act === exp) passed++;
      else $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
   endtask

   function automatic logic reads(input logic [31:0] i, input logic [4:0] r);
      logic [6:0] op;
      logic a, b;
      op = i[6:0];
      a = op != 7'b0110111 && op != 7'b0010111 && op != 7'b1101111 && i[19:15] == r;
      b = (op == 7'b0110011 || op == 7'b0100011 || op == 7'b1100011) && i[24:20] == r;
      return a || b;
   endfunction

   // model: what the spec rules demand this cycle, then advance to the situation after the edge
   always @(negedge clock) begin
      bit e_start, e_pc, e_fl, e_bub, e_to, lh, md, done_now;
      e_start = 0; e_pc = 1; e_fl = 0; e_bub = 0; e_to = 0;
      if (!reset) begin
         m_wait = 0; m_flush = 0; m_n = 0; m_sc = 0;
      end else begin
         lh = id_ex_memread && id_ex_rd != 0 && reads(if_id_instr, id_ex_rd);
         md = if_id_instr[6:0] == 7'b0110011 && if_id_instr[31:25] == 7'b0000001;
         if (ex_branch_taken || m_flush) begin
            e_fl = 1; e_bub = 1;
            m_flush = ex_branch_taken; m_wait = 0;
         end else if (m_wait) begin
            done_now = md_done || m_n == MAXC - 1;
            e_pc = done_now; e_bub = !done_now; e_to = !md_done && m_n == MAXC - 1;
            m_wait = !done_now; m_n++;
         end else if (lh) begin
            e_pc = 0; e_bub = 1;
         end else if (md) begin
            e_start = 1; e_pc = 0; e_bub = 1; m_wait = 1; m_n = 0;
         end
      end
      chk("md_start", md_start, e_start);
      chk("pc_write", pc_write, e_pc);
      chk("if_id_write", if_id_write, e_pc);
      chk("if_id_flush", if_id_flush, e_fl);
      chk("id_ex_bubble", id_ex_bubble, e_bub);
      chk("md_timeout", md_timeout, e_to);
`ifdef HAZ_STALL_CNT_EN
      chk("stall_count", stall_count, m_sc);
`else
      chk("stall_count", stall_count, 0);
`endif
      if (reset && !e_pc && m_sc < (1 << CW) - 1) m_sc++;
   end

   task automatic nxt();
      @(posedge clock);
      #1;
   endtask

   task automatic set(input logic [31:0] i, input logic mr, input logic [4:0] rd, input logic br, input logic dn);
      if_id_instr = i; id_ex_memread = mr; id_ex_rd = rd; ex_branch_taken = br; md_done = dn;
   endtask

   initial begin
      itab = '{ADD, ADD_X0, LUI5, SW5, ADDI5, MUL, NOP, JAL5, BEQ};
      set(ADD, 1, 5, 0, 0);
      #3;
      chk("rst pc_write", pc_write, 1);
      chk("rst bubble", id_ex_bubble, 0);
      chk("rst if_id_write", if_id_write, 1);
      nxt(); nxt();
      reset = 1; set(NOP, 0, 0, 0, 0);
      // load-use on x5
      nxt(); set(ADD, 1, 5, 0, 0); #1;
      chk("lu pc_write", pc_write, 0);
      chk("lu bubble", id_ex_bubble, 1);
      nxt(); set(ADD, 0, 5, 0, 0); #1;
      chk("lu after pc_write", pc_write, 1);
      // no-stall cases and rs2-usage boundary
      nxt(); set(ADD_X0, 1, 0, 0, 0); #1; chk("x0 pc_write", pc_write, 1);
      nxt(); set(LUI5, 1, 5, 0, 0); #1; chk("lui pc_write", pc_write, 1);
      nxt(); set(SW5, 1, 5, 0, 0); #1; chk("sw rs2 pc_write", pc_write, 0);
      nxt(); set(ADDI5, 1, 5, 0, 0); #1; chk("addi imm pc_write", pc_write, 1);
      // mul/div with md_done after 4 wait cycles
      nxt(); set(MUL, 0, 0, 0, 0); #1;
      chk("md start", md_start, 1);
      for (int k = 0; k < 4; k++) begin
         nxt(); #1;
         chk("md hold start", md_start, 0);
         chk("md hold pc", pc_write, 0);
      end
      nxt(); md_done = 1; #1;
      chk("md release pc", pc_write, 1);
      chk("md release bubble", id_ex_bubble, 0);
      nxt(); set(NOP, 0, 0, 0, 0); #1; chk("md after pc", pc_write, 1);
      // timeout in the 8th wait cycle
      nxt(); set(MUL, 0, 0, 0, 0); #1; chk("to start", md_start, 1);
      for (int k = 1; k <= MAXC; k++) begin
         nxt(); #1;
         chk("to pulse", md_timeout, k == MAXC);
         chk("to pc", pc_write, k == MAXC);
      end
      nxt(); set(NOP, 0, 0, 0, 0); #1;
      chk("to after", md_timeout, 0);
      chk("to after pc", pc_write, 1);
      // branch together with md_done in MDWAIT
      nxt(); set(MUL, 0, 0, 0, 0);
      nxt(); nxt();
      nxt(); ex_branch_taken = 1; md_done = 1; #1;
      chk("br+done flush", if_id_flush, 1);
      chk("br+done bubble", id_ex_bubble, 1);
      chk("br+done pc", pc_write, 1);
      nxt(); set(NOP, 0, 0, 0, 0); #1; chk("flush state", if_id_flush, 1);
      nxt(); md_done = 1; #1;
      chk("late done flush", if_id_flush, 0);
      chk("late done pc", pc_write, 1);
      // branch beats is_md in RUN, repeated branch holds FLUSH
      nxt(); set(MUL, 0, 0, 1, 0); #1;
      chk("br vs md start", md_start, 0);
      chk("br vs md flush", if_id_flush, 1);
      nxt(); set(NOP, 0, 0, 1, 0); #1; chk("flush+br", if_id_flush, 1);
      nxt(); ex_branch_taken = 0; #1; chk("flush held", if_id_flush, 1);
      nxt(); #1; chk("flush end", if_id_flush, 0);
      // load hazard beats is_md
      nxt(); set(MUL, 1, 1, 0, 0); #1;
      chk("lh vs md start", md_start, 0);
      chk("lh vs md pc", pc_write, 0);
      nxt(); id_ex_memread = 0; #1; chk("md after lh", md_start, 1);
      nxt(); md_done = 1;
      nxt(); set(NOP, 0, 0, 0, 0);
      // reset during MDWAIT
      nxt(); set(MUL, 0, 0, 0, 0);
      nxt(); nxt(); nxt();
      reset = 0; #1;
      chk("rst mdwait start", md_start, 0);
      chk("rst mdwait pc", pc_write, 1);
      chk("rst mdwait bubble", id_ex_bubble, 0);
      chk("rst mdwait count", stall_count, 0);
      nxt(); reset = 1; set(NOP, 0, 0, 0, 0); #1; chk("rst after pc", pc_write, 1);
      nxt(); md_done = 1; #1; chk("rst dropped wait", pc_write, 1);
      // random mix, checked by the model only
      for (int k = 0; k < 300; k++) begin
         nxt();
         set(itab[$urandom_range(8)], $urandom_range(9) < 3, 5'($urandom_range(7)),
             $urandom_range(9) == 0, $urandom_range(6) == 0);
      end
      nxt();
      $display("%0d/%0d checks passed", passed, total);
      $finish;
   end
endmodule
